sample_buffer: RTL and testbench

SAMPLE_BUFFER -- requirements
Module: sample_buffer

---
 rtl/sample_buffer_pkg.sv | 13 +
 rtl/sample_buffer_mem.sv | 36 +++
 rtl/sample_buffer.sv | 117 +++++++++++
 tb/tb_sample_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_buffer_pkg.sv
// Shared analyzer constants and the count-width helper used by the
// sample buffer, channel_input and the top level.
package sample_buffer_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;

    // A count that must reach DEPTH needs one more bit than a pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_buffer_mem.sv
// DEPTH x WIDTH storage: one write port and a read port whose address is
// registered, so the read data comes straight from the array.
module sample_buffer_mem
    import sample_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_raddr;

    // Write port and read-address register.
    // NOTE: the array has no reset; stale contents are harmless because the
    // pointers and count decide what is valid, and a reset would prevent RAM
    // inference.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, independent of statement order.
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_raddr <= i_raddr;
    end

    assign o_rdata = r_mem[r_raddr];

endmodule

// File: rtl/sample_buffer.sv
// First-word fall-through sample FIFO. Pointer, count and flag state lives
// here; storage is in sample_buffer_mem. Every output comes from a register
// or from the array, so strobes never reach outputs combinationally.
module sample_buffer
    import sample_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic                          i_save,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_read,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_available,
    output logic                          o_full,
    output logic                          o_overflow,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_available;
    logic          r_full;
    logic          r_overflow;

    logic [AW-1:0] w_wr_ptr_next;
    logic [AW-1:0] w_rd_ptr_next;
    logic [CW-1:0] w_count_next;
    logic          w_overflow_next;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_we;
    logic [AW-1:0] w_raddr;

    // A pop needs data; a write when full is accepted only alongside a pop.
    assign w_pop  = i_read && r_available;
    assign w_push = i_save && (!r_full || w_pop);
    assign w_drop = i_save && r_full && !w_pop;
    assign w_we   = w_push && !i_clear && !i_rst;

    // Next pointer/count/overflow state; clear overrides any strobe.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_wr_ptr_next   = r_wr_ptr;
        w_rd_ptr_next   = r_rd_ptr;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;
        if (i_clear) begin
            w_wr_ptr_next   = '0;
            w_rd_ptr_next   = '0;
            w_count_next    = '0;
            w_overflow_next = 1'b0;
        end else begin
            if (w_push) w_wr_ptr_next = r_wr_ptr + AW'(1);
            if (w_pop)  w_rd_ptr_next = r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CW'(1);
                2'b01:   w_count_next = r_count - CW'(1);
                default: w_count_next = r_count;
            endcase
            if (w_drop) w_overflow_next = 1'b1;
        end
    end

    // State registers with synchronous reset; flags are registered decodes
    // of the next count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_available <= 1'b0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_available <= (w_count_next != '0);
            r_full      <= (w_count_next == FULL_COUNT);
            r_overflow  <= w_overflow_next;
        end
    end

    // The read address tracks the next head so o_data is the head word one
    // cycle after any write into empty or any pop.
    assign w_raddr = i_rst ? '0 : w_rd_ptr_next;

    sample_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_data),
        .i_raddr (w_raddr),
        .o_rdata (o_data)
    );

    assign o_available = r_available;
    assign o_full      = r_full;
    assign o_overflow  = r_overflow;
    assign o_count     = r_count;

endmodule

// File: tb/tb_sample_buffer.sv
// Directed bench for sample_buffer (WIDTH=32, DEPTH=16).
module tb_sample_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic             clk;
    logic             i_rst;
    logic             i_clear;
    logic             i_save;
    logic [WIDTH-1:0] i_data;
    logic             i_read;
    logic [WIDTH-1:0] o_data;
    logic             o_available;
    logic             o_full;
    logic             o_overflow;
    logic [4:0]       o_count;

    int n_total = 0;
    int n_bad   = 0;

    sample_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_clear     (i_clear),
        .i_save      (i_save),
        .i_data      (i_data),
        .i_read      (i_read),
        .o_data      (o_data),
        .o_available (o_available),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rst = 1'b0; i_clear = 1'b0; i_save = 1'b0; i_read = 1'b0; i_data = '0;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        i_save = 1'b1; i_data = d;
        tick();
        i_save = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check(tag, o_data, exp);
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
    endtask

    // 17 writes to set overflow, then 11 pops leaves 5 words (11..15).
    task automatic five_with_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) push(32'(i));
        i_read = 1'b1;
        repeat (11) tick();
        i_read = 1'b0;
    endtask

    initial begin
        idle();
        tick();

        // Reset state
        do_reset();
        check("rst_count", 32'(o_count), 0);
        check("rst_avail", 32'(o_available), 0);
        check("rst_full",  32'(o_full), 0);
        check("rst_ovf",   32'(o_overflow), 0);

        // Basic pass
        push(32'h11);
        check("basic_avail_first", 32'(o_available), 1);
        check("basic_head_first", o_data, 32'h11);
        push(32'h22);
        push(32'h33);
        check("basic_count3", 32'(o_count), 3);
        pop_check("basic_pop0", 32'h11);
        check("basic_count2", 32'(o_count), 2);
        pop_check("basic_pop1", 32'h22);
        pop_check("basic_pop2", 32'h33);
        check("basic_count0", 32'(o_count), 0);
        check("basic_empty", 32'(o_available), 0);

        // Full and overflow
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(32'(i));
            if (i == 14) check("full_not_yet", 32'(o_full), 0);
            if (i == 15) begin
                check("full_after16", 32'(o_full), 1);
                check("full_count16", 32'(o_count), 16);
                check("full_ovf_clear", 32'(o_overflow), 0);
            end
        end
        check("ovf_set", 32'(o_overflow), 1);
        check("ovf_count16", 32'(o_count), 16);
        for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_pop%0d", i), 32'(i));
        check("ovf_drained", 32'(o_count), 0);
        check("ovf_sticky", 32'(o_overflow), 1);

        // Simultaneous write + pop while full
        do_reset();
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
        i_save = 1'b1; i_data = 32'hAA; i_read = 1'b1;
        check("sim_head_before", o_data, 32'h100);
        tick();
        idle();
        check("sim_count16", 32'(o_count), 16);
        check("sim_ovf0", 32'(o_overflow), 0);
        check("sim_full", 32'(o_full), 1);
        for (int i = 1; i < 16; i++) pop_check($sformatf("sim_pop%0d", i), 32'h100 + 32'(i));
        pop_check("sim_last_aa", 32'hAA);
        check("sim_empty", 32'(o_available), 0);

        // Wrap-around: count held at 2 through 40 write/pop pairs
        do_reset();
        push(32'd0);
        push(32'd1);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("wrap_head%0d", k), o_data, 32'(k));
            i_save = 1'b1; i_data = 32'(k + 2); i_read = 1'b1;
            tick();
            idle();
            if (o_full || o_count != 5'd2) check($sformatf("wrap_state%0d", k), {o_full, 26'd0, o_count}, 32'd2);
        end
        check("wrap_count", 32'(o_count), 2);
        check("wrap_full", 32'(o_full), 0);
        pop_check("wrap_tail0", 32'd40);
        pop_check("wrap_tail1", 32'd41);
        check("wrap_empty", 32'(o_count), 0);

        // Pop on empty
        do_reset();
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        check("empty_pop_count", 32'(o_count), 0);
        check("empty_pop_avail", 32'(o_available), 0);
        push(32'h5);
        check("empty_then_write", o_data, 32'h5);
        check("empty_then_count", 32'(o_count), 1);

        // Clear with a same-cycle save
        five_with_overflow();
        check("clr_pre_count", 32'(o_count), 5);
        check("clr_pre_ovf", 32'(o_overflow), 1);
        i_clear = 1'b1; i_save = 1'b1; i_data = 32'h99;
        tick();
        idle();
        check("clr_count", 32'(o_count), 0);
        check("clr_avail", 32'(o_available), 0);
        check("clr_ovf", 32'(o_overflow), 0);
        push(32'h77);
        check("clr_next_write", o_data, 32'h77);
        check("clr_next_count", 32'(o_count), 1);

        // Reset with same-cycle save and read
        five_with_overflow();
        i_rst = 1'b1; i_save = 1'b1; i_read = 1'b1; i_data = 32'h98;
        tick();
        idle();
        check("rstm_count", 32'(o_count), 0);
        check("rstm_avail", 32'(o_available), 0);
        check("rstm_ovf", 32'(o_overflow), 0);
        push(32'h66);
        check("rstm_next_write", o_data, 32'h66);
        check("rstm_next_avail", 32'(o_available), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
